// File: rtl/gpu_sched_pkg.sv
// Shared scheduler types: block-level FSM states and per-warp context status.
// Used by the warp scheduler, the core and the dispatcher.
package gpu_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } sched_state_t;

  typedef enum logic [2:0] {
    W_IDLE  = 3'd0,
    W_READY = 3'd1,
    W_RUN   = 3'd2,
    W_STALL = 3'd3,
    W_DONE  = 3'd4
  } warp_status_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of ready at or above ptr, with wrap.
// Shared by the warp scheduler and the LSU memory arbiter.
module rr_picker #(
  parameter int N         = 2,
  parameter int IDX_BITS  = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        ready,
  input  logic [IDX_BITS-1:0] ptr,
  output logic                found,
  output logic [IDX_BITS-1:0] idx
);

  logic [N-1:0] rot;

  // rot[j] is the request j slots past ptr; compare-based select keeps indices constant
  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++)
      for (int k = 0; k < N; k++)
        if (k == ((j + int'(ptr)) % N)) rot[j] = ready[k];
  end

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        idx   = IDX_BITS'((j + int'(ptr)) % N);
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: keeps PC/status for each warp of a block and runs one
// at a time, round-robin, parking warps that stall and retiring them on RET.
module warp_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int NUM_WARPS = 2,
  parameter int PC_BITS   = 8,
  parameter int WARP_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_BITS-1:0]   start_pc,
  input  logic                 commit_valid,
  input  logic [PC_BITS-1:0]   commit_pc,
  input  logic                 stall_valid,
  input  logic [PC_BITS-1:0]   stall_pc,
  input  logic                 ret_valid,
  input  logic [NUM_WARPS-1:0] wake,
  output logic                 active_valid,
  output logic [WARP_BITS-1:0] active_warp,
  output logic [PC_BITS-1:0]   active_pc,
  output logic [NUM_WARPS-1:0] warp_done,
  output logic                 block_done
);

  sched_state_t                           state_q, state_n;
  warp_status_t [NUM_WARPS-1:0]           status_q, status_n;
  logic         [NUM_WARPS-1:0][PC_BITS-1:0] pc_q, pc_n;
  logic         [WARP_BITS-1:0]           rr_q, rr_n;
  logic                                   av_q, av_n;
  logic         [WARP_BITS-1:0]           aw_q, aw_n;
  logic         [PC_BITS-1:0]             apc_q, apc_n;
  logic         [NUM_WARPS-1:0]           done_q, done_n;
  logic                                   bd_q, bd_n;

  logic [NUM_WARPS-1:0] ready_mask;
  logic                 all_done;
  logic                 pick_found;
  logic [WARP_BITS-1:0] pick_idx;

  always_comb begin
    ready_mask = '0;
    all_done   = 1'b1;
    for (int i = 0; i < NUM_WARPS; i++) begin
      ready_mask[i] = (status_q[i] == W_READY);
      if (status_q[i] != W_DONE) all_done = 1'b0;
    end
  end

  rr_picker #(.N(NUM_WARPS), .IDX_BITS(WARP_BITS)) u_pick (
    .ready (ready_mask),
    .ptr   (rr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n  = state_q;
    status_n = status_q;
    pc_n     = pc_q;
    rr_n     = rr_q;
    av_n     = av_q;
    aw_n     = aw_q;
    apc_n    = apc_q;
    done_n   = done_q;
    bd_n     = bd_q;

    // Wakes only release parked warps; a woken warp is picked from next cycle on
    for (int i = 0; i < NUM_WARPS; i++)
      if (wake[i] && status_q[i] == W_STALL) status_n[i] = W_READY;

    case (state_q)
      S_IDLE: begin
        av_n = 1'b0;
        if (start) begin
          for (int i = 0; i < NUM_WARPS; i++) begin
            status_n[i] = W_READY;
            pc_n[i]     = start_pc;
          end
          done_n  = '0;
          state_n = S_SELECT;
        end
      end
      S_SELECT: begin
        av_n = 1'b0;
        if (pick_found) begin
          for (int i = 0; i < NUM_WARPS; i++) begin
            if (pick_idx == WARP_BITS'(i)) begin
              status_n[i] = W_RUN;
              apc_n       = pc_q[i];
            end
          end
          av_n    = 1'b1;
          aw_n    = pick_idx;
          rr_n    = WARP_BITS'((int'(pick_idx) + 1) % NUM_WARPS);
          state_n = S_RUN;
        end else if (all_done) begin
          bd_n    = 1'b1;
          state_n = S_DONE;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NUM_WARPS; i++) begin
          if (aw_q == WARP_BITS'(i)) begin
            if (ret_valid) begin
              status_n[i] = W_DONE;
              done_n[i]   = 1'b1;
              av_n        = 1'b0;
              state_n     = S_SELECT;
            end else if (stall_valid) begin
              // A wake landing with the stall must not be lost
              pc_n[i]     = stall_pc;
              status_n[i] = wake[i] ? W_READY : W_STALL;
              av_n        = 1'b0;
              state_n     = S_SELECT;
            end else if (commit_valid) begin
              pc_n[i] = commit_pc;
              apc_n   = commit_pc;
            end
          end
        end
      end
      S_DONE: begin
        av_n = 1'b0;
        bd_n = 1'b1;
        if (!start) begin
          bd_n    = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NUM_WARPS; i++) status_q[i] <= W_IDLE;
      pc_q   <= '0;
      rr_q   <= '0;
      av_q   <= 1'b0;
      aw_q   <= '0;
      apc_q  <= '0;
      done_q <= '0;
      bd_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      status_q <= status_n;
      pc_q     <= pc_n;
      rr_q     <= rr_n;
      av_q     <= av_n;
      aw_q     <= aw_n;
      apc_q    <= apc_n;
      done_q   <= done_n;
      bd_q     <= bd_n;
    end
  end

  assign active_valid = av_q;
  assign active_warp  = aw_q;
  assign active_pc    = apc_q;
  assign warp_done    = done_q;
  assign block_done   = bd_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler with two warps: launch, commit, stall/wake,
// lost-wakeup race, retirement, block completion and mid-run reset.
module tb_warp_scheduler;

  localparam int NW = 2;
  localparam int PB = 8;
  localparam int WB = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [PB-1:0] start_pc;
  logic          commit_valid;
  logic [PB-1:0] commit_pc;
  logic          stall_valid;
  logic [PB-1:0] stall_pc;
  logic          ret_valid;
  logic [NW-1:0] wake;
  logic          active_valid;
  logic [WB-1:0] active_warp;
  logic [PB-1:0] active_pc;
  logic [NW-1:0] warp_done;
  logic          block_done;

  int vectors    = 0;
  int miscompares = 0;

  warp_scheduler #(.NUM_WARPS(NW), .PC_BITS(PB)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_pc     (start_pc),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .stall_valid  (stall_valid),
    .stall_pc     (stall_pc),
    .ret_valid    (ret_valid),
    .wake         (wake),
    .active_valid (active_valid),
    .active_warp  (active_warp),
    .active_pc    (active_pc),
    .warp_done    (warp_done),
    .block_done   (block_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_pc = '0; commit_valid = 1'b0; commit_pc = '0;
    stall_valid = 1'b0; stall_pc = '0; ret_valid = 1'b0; wake = '0;
    tick(); tick();
    vectors++; if (active_valid !== 1'b0) begin miscompares++; $display("FAIL reset_av: got %0b want 0", active_valid); end
    vectors++; if (active_warp !== 1'b0) begin miscompares++; $display("FAIL reset_aw: got %0d want 0", active_warp); end
    vectors++; if (active_pc !== 8'h00) begin miscompares++; $display("FAIL reset_apc: got %h want 00", active_pc); end
    vectors++; if (warp_done !== 2'b00) begin miscompares++; $display("FAIL reset_wd: got %b want 00", warp_done); end
    vectors++; if (block_done !== 1'b0) begin miscompares++; $display("FAIL reset_bd: got %0b want 0", block_done); end
    reset = 1'b0;
  endtask

  task automatic test_launch();
    wake = 2'b11;  // no warp stalled yet: must be ignored
    start = 1'b1; start_pc = 8'h10;
    tick();
    vectors++; if (active_valid !== 1'b0) begin miscompares++; $display("FAIL launch_sel_av: got %0b want 0", active_valid); end
    start = 1'b0; wake = '0;
    tick();
    vectors++; if ({active_valid, active_warp, active_pc} !== {1'b1, 1'b0, 8'h10})
      begin miscompares++; $display("FAIL launch_run: got v=%0b w=%0d pc=%h want v=1 w=0 pc=10", active_valid, active_warp, active_pc); end
  endtask

  task automatic test_commit_stall();
    commit_valid = 1'b1; commit_pc = 8'h11;
    tick();
    vectors++; if ({active_valid, active_pc} !== {1'b1, 8'h11}) begin miscompares++; $display("FAIL commit1: got v=%0b pc=%h want v=1 pc=11", active_valid, active_pc); end
    commit_pc = 8'h12;
    tick();
    vectors++; if ({active_valid, active_warp, active_pc} !== {1'b1, 1'b0, 8'h12}) begin miscompares++; $display("FAIL commit2: got v=%0b w=%0d pc=%h want v=1 w=0 pc=12", active_valid, active_warp, active_pc); end
    commit_valid = 1'b0; stall_valid = 1'b1; stall_pc = 8'h12;
    tick();
    vectors++; if (active_valid !== 1'b0) begin miscompares++; $display("FAIL stall_park: got v=%0b want 0", active_valid); end
    stall_valid = 1'b0;
    tick();
    vectors++; if ({active_valid, active_warp, active_pc} !== {1'b1, 1'b1, 8'h10}) begin miscompares++; $display("FAIL switch_w1: got v=%0b w=%0d pc=%h want v=1 w=1 pc=10", active_valid, active_warp, active_pc); end
  endtask

  task automatic test_all_stalled();
    stall_valid = 1'b1; stall_pc = 8'h20;
    tick();
    stall_valid = 1'b0;
    vectors++; if (active_valid !== 1'b0) begin miscompares++; $display("FAIL stall_w1: got v=%0b want 0", active_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++; if (active_valid !== 1'b0) begin miscompares++; $display("FAIL all_stalled_idle: cycle %0d got v=%0b want 0", c, active_valid); end
    end
    wake = 2'b01;
    tick();
    wake = '0;
    vectors++; if (active_valid !== 1'b0) begin miscompares++; $display("FAIL wake_latency: got v=%0b want 0", active_valid); end
    tick();
    vectors++; if ({active_valid, active_warp, active_pc} !== {1'b1, 1'b0, 8'h12}) begin miscompares++; $display("FAIL wake_resume: got v=%0b w=%0d pc=%h want v=1 w=0 pc=12", active_valid, active_warp, active_pc); end
  endtask

  task automatic test_stall_wake_race();
    stall_valid = 1'b1; stall_pc = 8'h30; wake = 2'b01;
    tick();
    stall_valid = 1'b0; wake = '0;
    vectors++; if (active_valid !== 1'b0) begin miscompares++; $display("FAIL race_park: got v=%0b want 0", active_valid); end
    tick();
    vectors++; if ({active_valid, active_warp, active_pc} !== {1'b1, 1'b0, 8'h30}) begin miscompares++; $display("FAIL race_resel: got v=%0b w=%0d pc=%h want v=1 w=0 pc=30", active_valid, active_warp, active_pc); end
  endtask

  task automatic test_retire();
    ret_valid = 1'b1; stall_valid = 1'b1; stall_pc = 8'h40;
    tick();
    ret_valid = 1'b0; stall_valid = 1'b0;
    vectors++; if ({active_valid, warp_done} !== {1'b0, 2'b01}) begin miscompares++; $display("FAIL ret_over_stall: got v=%0b wd=%b want v=0 wd=01", active_valid, warp_done); end
    tick();
    vectors++; if (active_valid !== 1'b0) begin miscompares++; $display("FAIL ret_w1_parked: got v=%0b want 0", active_valid); end
    wake = 2'b10;
    tick();
    wake = '0;
    tick();
    vectors++; if ({active_valid, active_warp, active_pc} !== {1'b1, 1'b1, 8'h20}) begin miscompares++; $display("FAIL w1_resume: got v=%0b w=%0d pc=%h want v=1 w=1 pc=20", active_valid, active_warp, active_pc); end
    ret_valid = 1'b1; start = 1'b1;  // start held so the block stays done
    tick();
    ret_valid = 1'b0;
    vectors++; if ({active_valid, warp_done, block_done} !== {1'b0, 2'b11, 1'b0}) begin miscompares++; $display("FAIL ret_w1: got v=%0b wd=%b bd=%0b want v=0 wd=11 bd=0", active_valid, warp_done, block_done); end
    tick();
    vectors++; if (block_done !== 1'b1) begin miscompares++; $display("FAIL block_done_set: got %0b want 1", block_done); end
    tick();
    vectors++; if (block_done !== 1'b1) begin miscompares++; $display("FAIL block_done_hold: got %0b want 1", block_done); end
    start = 1'b0;
    tick();
    vectors++; if ({block_done, warp_done, active_valid} !== {1'b0, 2'b11, 1'b0}) begin miscompares++; $display("FAIL block_done_clear: got bd=%0b wd=%b v=%0b want bd=0 wd=11 v=0", block_done, warp_done, active_valid); end
    tick();
    vectors++; if (active_valid !== 1'b0) begin miscompares++; $display("FAIL idle_stays: got v=%0b want 0", active_valid); end
  endtask

  task automatic test_reset_midrun();
    start = 1'b1; start_pc = 8'h50;
    tick();
    start = 1'b0;
    tick();
    vectors++; if ({active_valid, active_warp, active_pc, warp_done} !== {1'b1, 1'b0, 8'h50, 2'b00}) begin miscompares++; $display("FAIL relaunch: got v=%0b w=%0d pc=%h wd=%b want v=1 w=0 pc=50 wd=00", active_valid, active_warp, active_pc, warp_done); end
    commit_valid = 1'b1; commit_pc = 8'h51;
    tick();
    vectors++; if (active_pc !== 8'h51) begin miscompares++; $display("FAIL relaunch_commit: got %h want 51", active_pc); end
    reset = 1'b1; commit_pc = 8'h52; start = 1'b1;
    tick();
    commit_valid = 1'b0; start = 1'b0;
    vectors++; if ({active_valid, active_warp, active_pc, warp_done, block_done} !== '0) begin miscompares++; $display("FAIL midrun_reset: got v=%0b w=%0d pc=%h wd=%b bd=%0b want all 0", active_valid, active_warp, active_pc, warp_done, block_done); end
    reset = 1'b0;
    tick();
    vectors++; if (active_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: got v=%0b want 0", active_valid); end
    start = 1'b1; start_pc = 8'h60;
    tick();
    start = 1'b0;
    tick();
    vectors++; if ({active_valid, active_warp, active_pc} !== {1'b1, 1'b0, 8'h60}) begin miscompares++; $display("FAIL post_reset_launch: got v=%0b w=%0d pc=%h want v=1 w=0 pc=60", active_valid, active_warp, active_pc); end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_commit_stall();
    test_all_stalled();
    test_stall_wake_race();
    test_retire();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
